// File: rtl/dmem_bridge.sv
// Data-memory bridge between a single-issue core and a handshaked memory port.
// It posts stores into a one-entry buffer, forwards loads that hit that buffer, and aborts memory accesses whose ack never arrives.
module dmem_bridge #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [SIZE-1:0]       core_wdata,
    output logic [SIZE-1:0]       core_rdata,
    output logic                  core_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [SIZE-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [SIZE-1:0]       mem_rdata,
    output logic                  err
);

    // state   | meaning
    // IDLE    | no memory access outstanding
    // WR_BUSY | draining the write buffer, waiting for mem_ack
    // RD_BUSY | load issued to memory, waiting for mem_ack
    // RD_DONE | load data registered and handed to the core this cycle
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_BUSY = 2'd1;
    localparam logic [1:0] RD_BUSY = 2'd2;
    localparam logic [1:0] RD_DONE = 2'd3;

    // The abort decision is taken in the cycle that would push the counter to TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [SIZE-1:0]       wb_data_q, wb_data_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [SIZE-1:0]       mem_wdata_q, mem_wdata_d;
    logic [SIZE-1:0]       rd_data_q, rd_data_d;
    logic [SIZE-1:0]       last_q, last_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic is_load, is_store, fwd_hit, wr_ack, busy, tmo, store_accept;
    logic [SIZE-1:0] rdata_out;

    always_comb begin
        is_load      = core_req && !core_we;
        is_store     = core_req && core_we;
        fwd_hit      = is_load && wb_valid_q && (core_addr == wb_addr_q);
        wr_ack       = (state_q == WR_BUSY) && mem_ack;
        busy         = (state_q == WR_BUSY) || (state_q == RD_BUSY);
        tmo          = busy && !mem_ack && (cnt_q == TMO_LAST);
        store_accept = is_store && (!wb_valid_q || wr_ack);

        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (wr_ack || ((state_q == WR_BUSY) && tmo)) begin
            wb_valid_d = 1'b0;
        end
        if (store_accept) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = core_addr;
            wb_data_d  = core_wdata;
        end

        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                // Draining the buffer first keeps a later load behind an earlier store.
                if (wb_valid_d) begin
                    state_d     = WR_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wb_addr_d;
                    mem_wdata_d = wb_data_d;
                end else if (is_load && !fwd_hit) begin
                    state_d    = RD_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = core_addr;
                end
            end
            WR_BUSY: begin
                if (mem_ack || tmo) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = err_q || tmo;
                end
            end
            RD_BUSY: begin
                if (mem_ack) begin
                    state_d   = RD_DONE;
                    mem_req_d = 1'b0;
                    rd_data_d = mem_rdata;
                end else if (tmo) begin
                    state_d   = RD_DONE;
                    mem_req_d = 1'b0;
                    rd_data_d = '0;
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_d = (busy && (state_d == state_q)) ? cnt_q + 8'd1 : 8'd0;

        if (state_q == RD_DONE) begin
            rdata_out = rd_data_q;
        end else if (fwd_hit) begin
            rdata_out = wb_data_q;
        end else begin
            rdata_out = last_q;
        end
        last_d = rdata_out;

        if (is_store) begin
            core_stall = !store_accept;
        end else if (is_load) begin
            core_stall = !(fwd_hit || (state_q == RD_DONE));
        end else begin
            core_stall = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            last_q      <= '0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign core_rdata = rdata_out;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: posted stores, forwarding, load latency, drain ordering, timeout and reset.
// Inputs change 1ns after a rising edge; outputs are checked 2ns after it.
module tb_dmem_bridge;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        core_req, core_we;
    logic [9:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_stall;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int errors = 0;
    int checks = 0;
    int stalls;

    dmem_bridge #(.SIZE(32), .ADDR_WIDTH(10), .TIMEOUT(255)) dut (
        .CLK(CLK), .RESET(RESET),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic core_set(input logic req, input logic we, input logic [9:0] addr, input logic [31:0] wd);
        core_req   = req;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wd;
    endtask

    initial begin
        RESET = 1'b1;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick; tick;
        RESET = 1'b0;
        settle;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_stall", 32'(core_stall), 32'h0);

        // Posted store into an empty buffer, then a load of the same address after the ack.
        tick;
        core_set(1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
        settle;
        chk("st1_stall", 32'(core_stall), 32'h0);
        tick;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);
        settle;
        chk("st1_mem_req", 32'(mem_req), 32'h1);
        chk("st1_mem_we", 32'(mem_we), 32'h1);
        chk("st1_mem_addr", 32'(mem_addr), 32'h010);
        chk("st1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        settle;
        chk("st1_done_req", 32'(mem_req), 32'h0);
        core_set(1'b1, 1'b0, 10'h010, 32'h0);
        settle;
        chk("ld1_no_fwd_stall", 32'(core_stall), 32'h1);
        tick;
        settle;
        chk("ld1_mem_req", 32'(mem_req), 32'h1);
        chk("ld1_mem_we", 32'(mem_we), 32'h0);
        chk("ld1_mem_addr", 32'(mem_addr), 32'h010);
        mem_ack   = 1'b1;
        mem_rdata = 32'h11111111;
        settle;
        chk("ld1_stall_ack", 32'(core_stall), 32'h1);
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        settle;
        chk("ld1_release", 32'(core_stall), 32'h0);
        chk("ld1_rdata", core_rdata, 32'h11111111);
        tick;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);
        settle;
        chk("ld1_hold", core_rdata, 32'h11111111);
        chk("ld1_idle_stall", 32'(core_stall), 32'h0);
        chk("ld1_idle_req", 32'(mem_req), 32'h0);

        // Forwarding from the buffer while the store drains; a second store must wait.
        tick;
        core_set(1'b1, 1'b1, 10'h020, 32'h12345678);
        settle;
        chk("st2_stall", 32'(core_stall), 32'h0);
        tick;
        core_set(1'b1, 1'b0, 10'h020, 32'h0);
        settle;
        chk("fwd_stall", 32'(core_stall), 32'h0);
        chk("fwd_rdata", core_rdata, 32'h12345678);
        chk("fwd_mem_we", 32'(mem_we), 32'h1);
        tick;
        core_set(1'b1, 1'b1, 10'h024, 32'h24242424);
        settle;
        chk("st_full_stall", 32'(core_stall), 32'h1);
        chk("fwd_no_read", 32'(mem_we), 32'h1);
        core_set(1'b0, 1'b0, 10'h0, 32'h0);
        settle;
        chk("fwd_hold", core_rdata, 32'h12345678);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        settle;
        chk("st2_done_req", 32'(mem_req), 32'h0);

        // Load with three busy cycles before the ack: four stall cycles, then data.
        core_set(1'b1, 1'b0, 10'h030, 32'h0);
        stalls = 0;
        for (int c = 0; c < 8; c++) begin
            settle;
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hCAFEF00D;
                settle;
            end
            if (!core_stall) break;
            stalls++;
            tick;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        chk("ld3_stall_cycles", 32'(stalls), 32'd4);
        chk("ld3_rdata", core_rdata, 32'hCAFEF00D);
        tick;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);

        // Store accepted on the drain ack, then a pending load is ordered behind it.
        core_set(1'b1, 1'b1, 10'h040, 32'hAAAA0001);
        settle;
        chk("b2b_a_stall", 32'(core_stall), 32'h0);
        tick;
        core_set(1'b1, 1'b1, 10'h044, 32'hBBBB0002);
        mem_ack = 1'b1;
        settle;
        chk("b2b_a_addr", 32'(mem_addr), 32'h040);
        chk("b2b_b_stall", 32'(core_stall), 32'h0);
        tick;
        mem_ack = 1'b0;
        core_set(1'b1, 1'b0, 10'h060, 32'h0);
        settle;
        chk("order_ld_stall", 32'(core_stall), 32'h1);
        chk("b2b_gap_req", 32'(mem_req), 32'h0);
        tick;
        settle;
        chk("b2b_b_req", 32'(mem_req), 32'h1);
        chk("b2b_b_we", 32'(mem_we), 32'h1);
        chk("b2b_b_addr", 32'(mem_addr), 32'h044);
        chk("b2b_b_wdata", mem_wdata, 32'hBBBB0002);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        settle;
        chk("order_ld_wait", 32'(core_stall), 32'h1);
        tick;
        settle;
        chk("order_rd_we", 32'(mem_we), 32'h0);
        chk("order_rd_addr", 32'(mem_addr), 32'h060);
        mem_ack   = 1'b1;
        mem_rdata = 32'h00006666;
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        settle;
        chk("order_rd_stall", 32'(core_stall), 32'h0);
        chk("order_rd_data", core_rdata, 32'h00006666);
        tick;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);

        // Write that is never acknowledged: abort after 255 busy cycles.
        core_set(1'b1, 1'b1, 10'h070, 32'h77777777);
        tick;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);
        for (int c = 0; c < 254; c++) tick;
        settle;
        chk("tmo_before_err", 32'(err), 32'h0);
        chk("tmo_before_req", 32'(mem_req), 32'h1);
        tick;
        settle;
        chk("tmo_err", 32'(err), 32'h1);
        chk("tmo_req", 32'(mem_req), 32'h0);
        tick;
        settle;
        chk("tmo_err_sticky", 32'(err), 32'h1);
        chk("tmo_idle_req", 32'(mem_req), 32'h0);

        // Reset in the middle of a read; a late ack must be ignored.
        core_set(1'b1, 1'b0, 10'h080, 32'h0);
        tick;
        settle;
        chk("rrst_busy_req", 32'(mem_req), 32'h1);
        chk("rrst_busy_addr", 32'(mem_addr), 32'h080);
        RESET = 1'b1;
        core_set(1'b0, 1'b0, 10'h0, 32'h0);
        tick;
        RESET = 1'b0;
        settle;
        chk("rrst_req", 32'(mem_req), 32'h0);
        chk("rrst_addr", 32'(mem_addr), 32'h0);
        chk("rrst_wdata", mem_wdata, 32'h0);
        chk("rrst_rdata", core_rdata, 32'h0);
        chk("rrst_err", 32'(err), 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h99999999;
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick;
        settle;
        chk("late_ack_req", 32'(mem_req), 32'h0);
        chk("late_ack_rdata", core_rdata, 32'h0);
        chk("late_ack_stall", 32'(core_stall), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
